ifht_8pt: RTL and testbench

Inverse 8-point Fast Hadamard Transform. Accepts a block of eight signed transform coefficients on a valid/ready stream, runs three in-place radix-2 butterfly passes on an internal buffer, scales by 1/8, and streams eight reconstructed samples out. It sits on the receive side of the FHT datapath and undoes the forward 8-point transform back to sample width.

---
 rtl/ifht_8pt_if.sv | 25 ++
 rtl/ifht_8pt.sv | 132 +++++++++++++
 tb/tb_ifht_8pt.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ifht_8pt_if.sv
// Coefficient-in / sample-out stream bundle for the inverse 8-point FHT.
// The master side is the block's environment; the slave side is the transform itself.
interface ifht_8pt_if #(
    parameter int CW = 11,
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [CW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/ifht_8pt.sv
// Inverse 8-point FHT: load 8 coefficients, 3 in-place butterfly passes, scale by 1/8, unload 8 samples.
// Optional build macro IFHT_SAT_EN: saturate the scaled result instead of two's-complement wrap.
module ifht_8pt #(
    parameter int CW = 11,
    parameter int DW = 8
) (
    input  logic      clk,
    input  logic      reset,
    ifht_8pt_if.slave bus
);
    localparam int BW = CW + 3;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMP,
        ST_OUT
    } state_e;

    typedef logic signed [BW-1:0] word_t;

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [1:0]           stg_q, stg_d;
    word_t                buf_q [8];
    word_t                buf_d [8];
    logic [2:0]           span;
    logic signed [CW-1:0] shifted;
    logic signed [DW-1:0] scaled;

    // Butterfly partner distance for the current pass: 1, 2, 4.
    assign span = 3'b001 << stg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            stg_q   <= '0;
            // NOTE: the buffer is cleared on reset so out_data and the next block never see stale values.
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a hold default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        stg_d   = stg_q;
        for (int i = 0; i < 8; i++) begin
            buf_d[i] = buf_q[i];
        end

        unique case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    buf_d[idx_q] = word_t'(bus.in_data);
                    idx_d        = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        stg_d   = '0;
                        state_d = ST_COMP;
                    end
                end
            end

            ST_COMP: begin
                // All four butterflies of the pass run in parallel; growth is bounded by the 3 guard bits.
                for (int i = 0; i < 8; i++) begin
                    if ((3'(i) & span) == 3'b000) begin
                        buf_d[i]            = buf_q[i] + buf_q[3'(i) | span];
                        buf_d[3'(i) | span] = buf_q[i] - buf_q[3'(i) | span];
                    end
                end
                stg_d = stg_q + 2'd1;
                if (stg_q == 2'd2) begin
                    stg_d   = '0;
                    state_d = ST_OUT;
                end
            end

            ST_OUT: begin
                if (bus.out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
                stg_d   = '0;
            end
        endcase
    end

    // Divide by 8 with floor rounding; the result always fits in CW bits.
    assign shifted = CW'(buf_q[idx_q] >>> 3);

`ifdef IFHT_SAT_EN
    localparam logic signed [CW-1:0] SAT_MAX = CW'((2 ** (DW - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_MIN = CW'(-(2 ** (DW - 1)));

    always_comb begin
        scaled = shifted[DW-1:0];
        if (shifted > SAT_MAX) begin
            scaled = DW'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            scaled = DW'(SAT_MIN);
        end
    end
`else
    assign scaled = shifted[DW-1:0];
`endif

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.busy      = (state_q != ST_LOAD);
    assign bus.out_last  = (state_q == ST_OUT) && (idx_q == 3'd7);
    assign bus.out_data  = (state_q == ST_OUT) ? scaled : '0;

endmodule

// File: tb/tb_ifht_8pt.sv
// Directed bench for ifht_8pt: expected samples are queued at load time and popped as the DUT unloads.
// Random blocks derive their coefficients from a forward transform so the expected output is the original samples.
module tb_ifht_8pt;
    localparam int CW = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   coef [8];
    int   expv [8];
    int   samp [8];
    int   exp_q [$];
    int   t_a, t_b, t_tmp;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ifht_8pt_if #(.CW(CW), .DW(DW)) bus ();

    ifht_8pt #(.CW(CW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drives one block, one word per accepted beat; returns the cycle stamp just before the first accept.
    task automatic load_block(input int gap, input bit hold, output int t_first);
        int n;
        t_first = 0;
        for (int i = 0; i < 8; i++) begin
            if (gap > 0 && i > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = CW'(coef[i]);
            n = 0;
            while (!bus.in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("load_wait%0d", i), (n < 100), 1);
            if (i == 0) t_first = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        if (hold) bus.in_data = CW'(999);
        else      bus.in_valid = 1'b0;
    endtask

    // Unloads one block, comparing against the scoreboard; optional 5-cycle stall at sample bp_idx.
    task automatic drain(input int bp_idx);
        int lat;
        int e;
        bus.out_ready = 1'b1;
        check("busy_in_comp", bus.busy, 1);
        check("in_ready_in_comp", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        for (int k = 0; k < 8; k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h7fff_ffff;
            check($sformatf("valid%0d", k), bus.out_valid, 1);
            if (k == bp_idx) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid", bus.out_valid, 1);
                    check("bp_data", bus.out_data, e);
                    check("bp_in_ready", bus.in_ready, 0);
                end
                bus.out_ready = 1'b1;
            end
            check($sformatf("data%0d", k), bus.out_data, e);
            check($sformatf("last%0d", k), bus.out_last, (k == 7) ? 1 : 0);
            @(negedge clk);
        end
        check("in_ready_after_unload", bus.in_ready, 1);
        check("valid_after_unload", bus.out_valid, 0);
        check("busy_after_unload", bus.busy, 0);
    endtask

    task automatic run_block(input int gap, input int bp_idx, input bit hold, output int t_first);
        for (int i = 0; i < 8; i++) exp_q.push_back(expv[i]);
        load_block(gap, hold, t_first);
        drain(bp_idx);
    endtask

    task automatic set_round_trip();
        coef = '{36, -4, -8, 0, -16, 0, 0, 0};
        expv = '{1, 2, 3, 4, 5, 6, 7, 8};
    endtask

    // Forward transform as a direct sign-pattern sum, independent of the butterfly ordering.
    task automatic set_random();
        int acc;
        for (int j = 0; j < 8; j++) samp[j] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int j = 0; j < 8; j++) begin
                if ($countones(j & k) % 2 == 1) acc -= samp[j];
                else                            acc += samp[j];
            end
            coef[k] = acc;
            expv[k] = samp[k];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b1;
        @(negedge clk);

        // DC impulse
        coef = '{8, 0, 0, 0, 0, 0, 0, 0};
        expv = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_block(0, -1, 1'b0, t_tmp);

        // Back-to-back round trips with out_ready high: 19-cycle block period
        set_round_trip();
        run_block(0, -1, 1'b0, t_a);
        run_block(0, -1, 1'b0, t_b);
        check("block_period", t_b - t_a, 19);

        // Gapped load plus backpressure on sample index 2
        set_round_trip();
        run_block(2, 2, 1'b0, t_tmp);

        // Overflow: only sample 0 is out of range
        coef = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
`ifdef IFHT_SAT_EN
        expv = '{127, 0, 0, 0, 0, 0, 0, 0};
`else
        expv = '{-1, 0, 0, 0, 0, 0, 0, 0};
`endif
        run_block(0, -1, 1'b0, t_tmp);

        // Reset while pass 1 is pending; the half-computed block is discarded
        set_round_trip();
        for (int i = 0; i < 8; i++) exp_q.push_back(expv[i]);
        load_block(0, 1'b0, t_tmp);
        @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_round_trip();
        run_block(0, -1, 1'b0, t_tmp);

        // in_valid held high through COMP and OUT must not be absorbed
        set_round_trip();
        run_block(0, -1, 1'b1, t_tmp);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("held_valid_ignored", bus.in_ready, 1);
        set_round_trip();
        run_block(0, -1, 1'b0, t_tmp);

        // Random round trips, one with backpressure on the last sample
        for (int r = 0; r < 3; r++) begin
            set_random();
            run_block(r, (r == 2) ? 7 : -1, 1'b0, t_tmp);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
